// File: rtl/adc_frame_packer_pkg.sv
// -----------------------------------------------------------------------------
// adc_frame_packer_pkg
//   Shared types, constants and word-building helpers for adc_frame_packer.
//   - state_t      : framing FSM states (IDLE, DATA, TRL)
//   - HDR_MAGIC    : header tag in bits [63:48]
//   - TRL_MAGIC    : trailer tag in bits [63:48]
//   - FIFO_W       : readout FIFO word width (64)
//   - make_header  : {HDR_MAGIC, trigger, frame_seq, 16'h0}
//   - make_trailer : {TRL_MAGIC, count, drop_cnt, 14'h0, len_err, overflow}
//   - pack_lanes   : spreads up to 4 raw samples into 16-bit zero-extended lanes
//   - sat_inc16    : saturating 16-bit increment
// -----------------------------------------------------------------------------
package adc_frame_packer_pkg;

    localparam int          FIFO_W    = 64;
    localparam logic [15:0] HDR_MAGIC = 16'hA5C3;
    localparam logic [15:0] TRL_MAGIC = 16'h5A3C;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_TRL  = 2'd2
    } state_t;

    function automatic logic [FIFO_W-1:0] make_header(
        input logic [15:0] trig,
        input logic [15:0] seq
    );
        return {HDR_MAGIC, trig, seq, 16'h0000};
    endfunction

    function automatic logic [FIFO_W-1:0] make_trailer(
        input logic [15:0] count,
        input logic [15:0] drops,
        input logic        len_err,
        input logic        ovf
    );
        return {TRL_MAGIC, count, drops, 14'd0, len_err, ovf};
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // raw holds num_ch samples of adc_bits each, packed from bit 0 upward.
    // Lane k of the result is sample k zero-extended to 16 bits; lanes at or
    // above num_ch stay zero.
    function automatic logic [FIFO_W-1:0] pack_lanes(
        input logic [63:0] raw,
        input int          num_ch,
        input int          adc_bits
    );
        logic [63:0] word;
        logic [63:0] mask;
        logic [63:0] lane;
        word = '0;
        mask = (64'd1 << adc_bits) - 64'd1;
        for (int k = 0; k < 4; k++) begin
            lane = '0;
            if (k < num_ch) begin
                lane = (raw >> (k * adc_bits)) & mask;
            end
            word = word | (lane << (16 * k));
        end
        return word;
    endfunction

endpackage

// File: rtl/adc_frame_packer.sv
// -----------------------------------------------------------------------------
// adc_frame_packer
//   Frames AD9228 sample sets into header / data / trailer words and writes
//   one 64-bit word per clock into the readout FIFO, counting dropped words.
//
//   Build option: define ADC_FRAME_PACKER_TEST_PATTERN_EN to replace adc_data
//   with a counting pattern (lane k of sample i = i*NUM_CH + k, truncated to
//   ADC_BITS). Framing is identical in both builds.
//
//   Ports
//     clk            in   readout clock
//     rstn           in   asynchronous active-low reset
//     AD9228_read_en in   adc_data holds a valid sample set this cycle
//     adc_data       in   NUM_CH*ADC_BITS, channel k at [k*ADC_BITS +: ADC_BITS]
//     trigger_count  in   16-bit trigger counter, captured into the header
//     fifo_full      in   readout FIFO full flag
//     fifo_din       out  64-bit FIFO write data
//     fifo_wr_en     out  FIFO write strobe
//     frame_done     out  one-cycle pulse on the trailer edge
//     overflow       out  sticky: a word was dropped in the current/last frame
//     frame_seq      out  completed-frame counter (wraps)
//     o_dbg_state    out  current FSM state (state_t encoding)
//
//   FIFO write contract: there is no ready/back-pressure path. A word is
//   written when fifo_wr_en=1 on a rising edge. A word that falls due while
//   fifo_full=1 is dropped (fifo_wr_en stays 0), counted in drop_cnt and flagged
//   in overflow; the framing FSM never stalls.
// -----------------------------------------------------------------------------
module adc_frame_packer
    import adc_frame_packer_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int ADC_BITS    = 12,
    parameter int MAX_SAMPLES = 1280
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       AD9228_read_en,
    input  logic [NUM_CH*ADC_BITS-1:0] adc_data,
    input  logic [15:0]                trigger_count,
    input  logic                       fifo_full,
    output logic [FIFO_W-1:0]          fifo_din,
    output logic                       fifo_wr_en,
    output logic                       frame_done,
    output logic                       overflow,
    output logic [15:0]                frame_seq,
    output logic [1:0]                 o_dbg_state
);

    localparam int          SAMPLE_W = NUM_CH * ADC_BITS;
    localparam logic [15:0] MAX_CNT  = 16'(MAX_SAMPLES);

    state_t              r_state;
    state_t              w_next_state;

    logic [SAMPLE_W-1:0] r_hold;
    logic                r_hold_valid;
    logic [15:0]         r_count;
    logic [15:0]         r_drop_cnt;
    logic                r_len_err;
    logic                r_overflow;
    logic [15:0]         r_frame_seq;
    logic [FIFO_W-1:0]   r_fifo_din;
    logic                r_fifo_wr_en;
    logic                r_frame_done;

    logic                w_emit;      // a word falls due on this edge
    logic [FIFO_W-1:0]   w_word;
    logic                w_start;     // header edge: opens a new frame
    logic                w_capture;   // accept the current sample into hold
    logic                w_discard;   // sample beyond MAX_SAMPLES
    logic                w_trl;
    logic                w_drop;
    logic                w_write;
    logic [SAMPLE_W-1:0] w_sample;
    logic [63:0]         w_hold_ext;

    assign w_hold_ext = 64'(r_hold);
    assign w_drop     = w_emit & fifo_full;
    assign w_write    = w_emit & ~fifo_full;

    // ---------------------------------------------------------------- sample
`ifdef ADC_FRAME_PACKER_TEST_PATTERN_EN
    // Sample index equals the number of samples already accepted this frame;
    // the header edge captures index 0.
    logic [15:0] w_idx;
    assign w_idx = w_start ? 16'd0 : r_count;

    always_comb begin
        w_sample = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_sample[k*ADC_BITS +: ADC_BITS] =
                ADC_BITS'(32'(w_idx) * 32'(NUM_CH) + 32'(k));
        end
    end
`else
    assign w_sample = adc_data;
`endif

    // ------------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_emit       = 1'b0;
        w_word       = '0;
        w_start      = 1'b0;
        w_capture    = 1'b0;
        w_discard    = 1'b0;
        w_trl        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (AD9228_read_en) begin
                    w_emit       = 1'b1;
                    w_word       = make_header(trigger_count, r_frame_seq);
                    w_start      = 1'b1;
                    w_next_state = ST_DATA;
                end
            end
            ST_DATA: begin
                // hold goes invalid once the frame is over-length, which
                // silences data words until the trailer.
                w_emit = r_hold_valid;
                w_word = pack_lanes(w_hold_ext, NUM_CH, ADC_BITS);
                if (AD9228_read_en) begin
                    if (r_count < MAX_CNT) begin
                        w_capture = 1'b1;
                    end else begin
                        w_discard = 1'b1;
                    end
                end else begin
                    w_next_state = ST_TRL;
                end
            end
            ST_TRL: begin
                // read_en is ignored here; a sample arriving now is lost.
                w_emit       = 1'b1;
                w_trl        = 1'b1;
                w_word       = make_trailer(
                                   r_count,
                                   fifo_full ? sat_inc16(r_drop_cnt) : r_drop_cnt,
                                   r_len_err,
                                   r_overflow | fifo_full);
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_count      <= '0;
            r_drop_cnt   <= '0;
            r_len_err    <= 1'b0;
            r_overflow   <= 1'b0;
            r_frame_seq  <= '0;
            r_fifo_din   <= '0;
            r_fifo_wr_en <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_fifo_wr_en <= w_write;
            if (w_write) begin
                r_fifo_din <= w_word;
            end
            r_frame_done <= w_trl;
            if (w_trl) begin
                r_frame_seq <= r_frame_seq + 16'd1;
            end
            if (w_start) begin
                // Per-frame accounting restarts here; a dropped header is the
                // first drop of the new frame.
                r_hold       <= w_sample;
                r_hold_valid <= 1'b1;
                r_count      <= 16'd1;
                r_len_err    <= 1'b0;
                r_drop_cnt   <= {15'd0, fifo_full};
                r_overflow   <= fifo_full;
            end else begin
                if (w_drop) begin
                    r_drop_cnt <= sat_inc16(r_drop_cnt);
                    r_overflow <= 1'b1;
                end
                if (w_capture) begin
                    r_hold  <= w_sample;
                    r_count <= r_count + 16'd1;
                end
                if (w_discard) begin
                    r_len_err    <= 1'b1;
                    r_hold_valid <= 1'b0;
                end
            end
        end
    end

    assign fifo_din    = r_fifo_din;
    assign fifo_wr_en  = r_fifo_wr_en;
    assign frame_done  = r_frame_done;
    assign overflow    = r_overflow;
    assign frame_seq   = r_frame_seq;
    assign o_dbg_state = r_state;

endmodule
